// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding byte/half/word access on a word-wide memory port
// with byte enables, load extraction, misalignment and timeout faults.
module load_store_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       rs1_val,
  input  logic [31:0]       rs2_val,
  input  logic [31:0]       imm,
  input  logic [4:0]        rd_in,
  input  logic [2:0]        load_control,
  input  logic [1:0]        store_control,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              stall_pc,
  output logic              ignore_curr_inst,
  output logic              rd_write_control,
  output logic [4:0]        rd_out,
  output logic [31:0]       rd_write_val,
  output logic              misalign_fault,
  output logic              timeout_fault
);

  // state | meaning
  // IDLE  | waiting for an operation; accepts in the same cycle it is presented
  // REQ   | memory request held until mem_ready
  // WAIT  | load issued, waiting for mem_rvalid
  // DONE  | one-cycle completion: squash, writeback or fault pulse
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              is_load_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [4:0]        rd_q;
  logic [31:0]       rs2_q;
  logic [31:0]       rdata_q;
  logic [7:0]        cnt_q;
  logic              misalign_q;
  logic              timeout_q;
  logic              load_ok_q;

  logic              ld_op;
  logic              st_op;
  logic              accept;
  logic [1:0]        size_in;
  logic              uns_in;
  logic [ADDR_W-1:0] ea;
  logic              mis_in;
  logic [3:0]        be;
  logic [31:0]       wdata;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane,
                                          input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    return uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  // size: 0 byte, 1 halfword, 2 word; a load takes priority over a store
  always_comb begin
    ld_op   = (load_control >= 3'd1) && (load_control <= 3'd5);
    st_op   = (store_control != 2'd0);
    accept  = ld_op || st_op;
    size_in = 2'd2;
    uns_in  = 1'b0;
    if (ld_op) begin
      case (load_control)
        3'd1:    size_in = 2'd0;
        3'd2:    size_in = 2'd1;
        3'd4:    begin size_in = 2'd0; uns_in = 1'b1; end
        3'd5:    begin size_in = 2'd1; uns_in = 1'b1; end
        default: size_in = 2'd2;
      endcase
    end else begin
      case (store_control)
        2'd1:    size_in = 2'd0;
        2'd2:    size_in = 2'd1;
        default: size_in = 2'd2;
      endcase
    end
    ea     = ADDR_W'(rs1_val + imm);
    mis_in = ((size_in == 2'd1) && ea[0]) || ((size_in == 2'd2) && (ea[1:0] != 2'b00));
  end

  always_comb begin
    be    = 4'b1111;
    wdata = rs2_q;
    if (!is_load_q) begin
      case (size_q)
        2'd0:    begin be = 4'b0001 << addr_q[1:0]; wdata = {4{rs2_q[7:0]}};  end
        2'd1:    begin be = 4'b0011 << addr_q[1:0]; wdata = {2{rs2_q[15:0]}}; end
        default: begin be = 4'b1111;                wdata = rs2_q;            end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      is_load_q  <= 1'b0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      rd_q       <= 5'd0;
      rs2_q      <= 32'd0;
      rdata_q    <= 32'd0;
      cnt_q      <= 8'd0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      load_ok_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q     <= ea;
            is_load_q  <= ld_op;
            size_q     <= size_in;
            uns_q      <= uns_in;
            rd_q       <= rd_in;
            rs2_q      <= rs2_val;
            cnt_q      <= 8'd0;
            misalign_q <= mis_in;
            timeout_q  <= 1'b0;
            load_ok_q  <= 1'b0;
            state      <= mis_in ? DONE : REQ;
          end
        end
        REQ: begin
          // progress wins over timeout on the last permitted cycle
          if (mem_ready) begin
            cnt_q <= 8'd0;
            state <= is_load_q ? WAIT : DONE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            state     <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            rdata_q   <= extract(mem_rdata, addr_q[1:0], size_q, uns_q);
            load_ok_q <= 1'b1;
            state     <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            state     <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          misalign_q <= 1'b0;
          timeout_q  <= 1'b0;
          load_ok_q  <= 1'b0;
          cnt_q      <= 8'd0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign mem_req          = (state == REQ);
  assign mem_we           = (state == REQ) && !is_load_q;
  assign mem_addr         = (state == REQ) ? addr_q : '0;
  assign mem_be           = (state == REQ) ? be : 4'd0;
  assign mem_wdata        = ((state == REQ) && !is_load_q) ? wdata : 32'd0;
  assign stall_pc         = ((state == IDLE) && accept && !i_rst) || (state == REQ) || (state == WAIT);
  assign ignore_curr_inst = (state == DONE);
  assign rd_write_control = (state == DONE) && load_ok_q;
  assign rd_out           = rd_write_control ? rd_q : 5'd0;
  assign rd_write_val     = rd_write_control ? rdata_q : 32'd0;
  assign misalign_fault   = (state == DONE) && misalign_q;
  assign timeout_fault    = (state == DONE) && timeout_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random accesses checked cycle by cycle against
// an arithmetic model of address, enables, lane data, extraction and phase lengths.
module tb_load_store_unit;
  localparam int T = 15;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] rs1_val, rs2_val, imm;
  logic [4:0]  rd_in;
  logic [2:0]  load_control;
  logic [1:0]  store_control;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        stall_pc, ignore_curr_inst, rd_write_control;
  logic [4:0]  rd_out;
  logic [31:0] rd_write_val;
  logic        misalign_fault, timeout_fault;

  int errors = 0;
  int checks = 0;
  int op_idx = 0;
  int cyc = 0;

  load_store_unit #(.ADDR_W(32), .TIMEOUT(T)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .rd_in(rd_in), .load_control(load_control), .store_control(store_control),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .stall_pc(stall_pc), .ignore_curr_inst(ignore_curr_inst),
    .rd_write_control(rd_write_control), .rd_out(rd_out), .rd_write_val(rd_write_val),
    .misalign_fault(misalign_fault), .timeout_fault(timeout_fault)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s op%0d cyc%0d observed=%0h expected=%0h", tag, op_idx, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_outputs(input logic req, input logic we, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wd, input logic stall,
                             input logic ign, input logic rdw, input logic [4:0] rdo,
                             input logic [31:0] rdv, input logic mis, input logic to);
    chk("mem_req", 32'(mem_req), 32'(req));
    chk("mem_we", 32'(mem_we), 32'(we));
    chk("mem_addr", mem_addr, addr);
    chk("mem_be", 32'(mem_be), 32'(be));
    chk("mem_wdata", mem_wdata, wd);
    chk("stall_pc", 32'(stall_pc), 32'(stall));
    chk("ignore_curr_inst", 32'(ignore_curr_inst), 32'(ign));
    chk("rd_write_control", 32'(rd_write_control), 32'(rdw));
    chk("rd_out", 32'(rd_out), 32'(rdo));
    chk("rd_write_val", rd_write_val, rdv);
    chk("misalign_fault", 32'(misalign_fault), 32'(mis));
    chk("timeout_fault", 32'(timeout_fault), 32'(to));
  endtask

  task automatic nop_inputs();
    load_control  = 3'd0;
    store_control = 2'd0;
    rs1_val = $urandom; rs2_val = $urandom; imm = $urandom; rd_in = 5'($urandom);
  endtask

  // dr: REQ cycles without ready before ready; dv: WAIT cycles before rvalid
  task automatic run_op(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] rs1,
                        input logic [31:0] im, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic [31:0] rdata, input int dr, input int dv);
    bit is_ld, uns, mis, to, to2;
    int nbytes, nr, nw, done_k, lane;
    logic [31:0] addr, be, wd, mask, val;
    logic e_req, e_we, e_stall, e_ign, e_rdw, e_mis, e_to;
    logic [31:0] e_addr, e_wd, e_rdv;
    logic [3:0] e_be;
    logic [4:0] e_rdo;
    op_idx++;
    is_ld  = (ld >= 3'd1 && ld <= 3'd5);
    uns    = (ld == 3'd4 || ld == 3'd5);
    if (is_ld) nbytes = (ld == 3'd3) ? 4 : ((ld == 3'd2 || ld == 3'd5) ? 2 : 1);
    else       nbytes = (st == 2'd3) ? 4 : ((st == 2'd2) ? 2 : 1);
    addr = rs1 + im;
    lane = int'(addr % 4);
    mis  = (addr % nbytes) != 0;
    be   = is_ld ? 32'd15 : (((32'd1 << nbytes) - 1) << lane);
    wd   = (nbytes == 1) ? rs2[7:0] * 32'h01010101 :
           (nbytes == 2) ? rs2[15:0] * 32'h00010001 : rs2;
    mask = (nbytes == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * nbytes)) - 1);
    val  = (rdata >> (8 * lane)) & mask;
    if (!uns && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
    to  = !mis && dr >= T;
    to2 = !mis && !to && is_ld && dv >= T;
    nr  = mis ? 0 : (to ? T : dr + 1);
    nw  = (!mis && !to && is_ld) ? (to2 ? T : dv + 1) : 0;
    done_k = nr + nw + 1;
    for (int k = 0; k <= done_k + 1; k++) begin
      cyc = k;
      i_rst = 1'b0;
      if (k == 0) begin
        load_control = ld; store_control = st;
        rs1_val = rs1; imm = im; rs2_val = rs2; rd_in = rd;
      end else if (k <= done_k) begin
        load_control = 3'($urandom); store_control = 2'($urandom);
        rs1_val = $urandom; imm = $urandom; rs2_val = $urandom; rd_in = 5'($urandom);
      end else begin
        nop_inputs();
      end
      mem_ready  = (k >= 1 && k <= nr) ? (k == 1 + dr) : 1'($urandom);
      mem_rvalid = (k > nr && k <= nr + nw) ? (k == nr + 1 + dv) : 1'($urandom);
      mem_rdata  = (k > nr && k <= nr + nw) ? rdata : $urandom;
      #1;
      e_req = 0; e_we = 0; e_addr = 0; e_be = 0; e_wd = 0; e_stall = 0; e_ign = 0;
      e_rdw = 0; e_rdo = 0; e_rdv = 0; e_mis = 0; e_to = 0;
      if (k == 0) begin
        e_stall = 1;
      end else if (k <= nr) begin
        e_req = 1; e_we = !is_ld; e_addr = addr; e_be = be[3:0];
        e_wd = is_ld ? 32'd0 : wd; e_stall = 1;
      end else if (k < done_k) begin
        e_stall = 1;
      end else if (k == done_k) begin
        e_ign = 1; e_mis = mis; e_to = to || to2;
        if (is_ld && !mis && !to && !to2) begin
          e_rdw = 1; e_rdo = rd; e_rdv = val;
        end
      end
      chk_outputs(e_req, e_we, e_addr, e_be, e_wd, e_stall, e_ign, e_rdw, e_rdo, e_rdv,
                  e_mis, e_to);
      tick();
    end
  endtask

  // reset arrives while the load sits in REQ (in_wait=0) or WAIT (in_wait=1)
  task automatic reset_mid(input bit in_wait);
    op_idx++;
    cyc = 0;
    i_rst = 1'b0; load_control = 3'd3; store_control = 2'd0;
    rs1_val = 32'h500; imm = 32'd0; rd_in = 5'd7;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    tick();
    nop_inputs();
    if (in_wait) begin
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
    end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc = k + 1;
      mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom;
      #1;
      chk_outputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    logic [2:0] ld;
    logic [1:0] st;
    i_rst = 1'b1;
    nop_inputs();
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    tick();
    tick();
    cyc = 0;
    chk_outputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // release cycle accepts immediately
    run_op(3'd3, 2'd0, 32'h100, 32'd4, 32'd0, 5'd5, 32'hDEADBEEF, 0, 0);
    run_op(3'd1, 2'd0, 32'h200, 32'd3, 32'd0, 5'd6, 32'h80AA55CC, 0, 1);
    run_op(3'd4, 2'd0, 32'h200, 32'd3, 32'd0, 5'd6, 32'h80AA55CC, 1, 0);
    run_op(3'd0, 2'd2, 32'h300, 32'd2, 32'h1234ABCD, 5'd1, 32'd0, 3, 0);
    run_op(3'd3, 2'd0, 32'h400, 32'd1, 32'd0, 5'd2, 32'd0, 0, 0);
    run_op(3'd3, 2'd0, 32'h600, 32'd0, 32'd0, 5'd3, 32'h11112222, T, 0);
    run_op(3'd3, 2'd0, 32'h600, 32'd0, 32'd0, 5'd3, 32'h11112222, T - 1, 0);
    run_op(3'd2, 2'd0, 32'h700, 32'd2, 32'd0, 5'd9, 32'h8001_7FFF, 0, T);
    run_op(3'd2, 2'd0, 32'h700, 32'd2, 32'd0, 5'd9, 32'h8001_7FFF, 0, T - 1);
    run_op(3'd5, 2'd0, 32'h700, 32'd2, 32'd0, 5'd10, 32'h8001_7FFF, 2, 2);
    run_op(3'd3, 2'd3, 32'h800, 32'd8, 32'hCAFEF00D, 5'd11, 32'h0BADC0DE, 0, 0);
    run_op(3'd7, 2'd1, 32'hFFFF_FFFC, 32'd9, 32'h0000_00A5, 5'd0, 32'd0, 1, 0);
    run_op(3'd0, 2'd3, 32'hFFFF_FFFC, 32'd8, 32'h5A5A_1234, 5'd0, 32'd0, 0, 0);
    run_op(3'd0, 2'd2, 32'h900, 32'd1, 32'h1234_5678, 5'd0, 32'd0, 0, 0);

    reset_mid(1'b1);
    reset_mid(1'b0);
    i_rst = 1'b1;
    nop_inputs();
    tick();
    run_op(3'd1, 2'd0, 32'h1000, 32'd1, 32'd0, 5'd31, 32'h0000_7F00, 0, 0);

    for (int n = 0; n < 60; n++) begin
      ld = 3'($urandom);
      st = 2'($urandom);
      if (!(ld >= 3'd1 && ld <= 3'd5) && st == 2'd0) ld = 3'd3;
      run_op(ld, st, $urandom, 32'($urandom_range(0, 7)), $urandom, 5'($urandom), $urandom,
             ($urandom_range(0, 9) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(0, 3),
             ($urandom_range(0, 9) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
